nibble_add_seq: RTL

Multi-precision add/subtract sequencer built around the team's 4-bit ripple-carry adder stage. It captures two NIBBLES×4-bit operands on a start handshake and feeds the 4-bit adder one nibble per cycle, least-significant first, through a registered inter-nibble carry. It returns the full sum, the final carry and the signed overflow with a done pulse. It lets wide arithmetic reuse a single 4-bit adder instead of a wide combinational chain.

---
 rtl/nibble_add_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/nibble_add_seq.sv
// Multi-precision add/sub reusing one 4-bit ripple stage, LSB nibble first; latency NIBBLES cycles.
// No backpressure: start is only sampled in IDLE/DONE, requester waits for the done pulse.

module nibble_adder4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       ci_i,
    output logic [3:0] s_o,
    output logic [3:0] co_o
);
    logic c;

    always_comb begin
        c    = ci_i;
        s_o  = '0;
        co_o = '0;
        for (int i = 0; i < 4; i++) begin
            s_o[i]  = a_i[i] ^ b_i[i] ^ c;
            co_o[i] = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
            c       = co_o[i];
        end
    end
endmodule

module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 sub_i,
    input  logic [4*NIBBLES-1:0] a_i,
    input  logic [4*NIBBLES-1:0] b_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4*NIBBLES-1:0] sum_o,
    output logic                 c_out_o,
    output logic                 overflow_o
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic            sub_q, sub_d, carry_q, carry_d;
    logic            c_out_q, c_out_d, ovf_q, ovf_d;
    logic [IDXW-1:0] idx_q, idx_d;

    logic [3:0] a_nib, b_nib, nib_sum;
    logic       nib_c3, nib_c2;
    logic [1:0] unused_lo_carry;

    assign a_nib = a_q[{idx_q, 2'b00} +: 4];
    assign b_nib = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};

    nibble_adder4 u_add (
        .a_i  (a_nib),
        .b_i  (b_nib),
        .ci_i (carry_q),
        .s_o  (nib_sum),
        .co_o ({nib_c3, nib_c2, unused_lo_carry})
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_RUN;
                    a_d     = a_i;
                    b_d     = b_i;
                    sub_d   = sub_i;
                    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
                    carry_d = sub_i;
                    idx_d   = '0;
                    sum_d   = '0;
                    c_out_d = 1'b0;
                    ovf_d   = 1'b0;
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = nib_sum;
                carry_d = nib_c3;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    c_out_d = nib_c3;
                    ovf_d   = nib_c3 ^ nib_c2;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o     = (state_q == S_RUN);
    assign done_o     = (state_q == S_DONE);
    assign sum_o      = sum_q;
    assign c_out_o    = c_out_q;
    assign overflow_o = ovf_q;
endmodule
